timer_panel: RTL and testbench

TIMER_PANEL -- requirements
Module: timer_panel

---
 rtl/timer_panel.sv | 183 ++++++++++++++++++
 tb/tb_timer_panel.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_panel.sv
// Button front panel for a countdown timer: debounced buttons,
// auto-repeat, run/abort control and a beeping alarm.
module timer_panel #(
   parameter int DEBOUNCE     = 4,
   parameter int REPEAT_DELAY = 8,
   parameter int REPEAT_RATE  = 4,
   parameter int BEEP_LEN     = 6,
   parameter int BEEP_COUNT   = 3
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       btn_plus,
   input  logic       btn_minus,
   input  logic       btn_start,
   input  logic       timer_finish,
   output logic       tmr_plus,
   output logic       tmr_minus,
   output logic       tmr_start,
   output logic       tmr_reset,
   output logic       buzzer,
   output logic [1:0] state
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_ALARM = 2'd2;

   localparam int DW   = $clog2(DEBOUNCE + 1);
   localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ?
                         REPEAT_DELAY : REPEAT_RATE;
   localparam int RW   = $clog2(RMAX + 1);
   localparam int BW   = $clog2(BEEP_LEN + 1);

   logic [2:0]    raw;
   logic [2:0]    sync1;
   logic [2:0]    sync2;
   logic [2:0]    db;
   logic [2:0]    db_q;
   logic [2:0]    lk;
   logic [DW-1:0] dcnt [3];

   logic [2:0]    en;
   logic [2:0]    rise;
   logic          hp;
   logic          hm;
   logic          hp_q;
   logic          hm_q;
   logic          fresh_p;
   logic          fresh_m;
   logic          srise;

   logic [RW-1:0] rcnt;
   logic [RW-1:0] rtgt;
   logic          rep;
   logic          rtick;

   logic [BW-1:0] pcnt;
   logic [3:0]    bleft;

   assign raw = {btn_start, btn_minus, btn_plus};

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync1 <= '0;
         sync2 <= '0;
         db    <= '0;
         for (int i = 0; i < 3; i++) dcnt[i] <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         for (int i = 0; i < 3; i++) begin
            if (sync2[i] != db[i]) begin
               if (dcnt[i] == DW'(DEBOUNCE - 1)) begin
                  db[i]   <= sync2[i];
                  dcnt[i] <= '0;
               end else begin
                  dcnt[i] <= dcnt[i] + 1'b1;
               end
            end else begin
               dcnt[i] <= '0;
            end
         end
      end
   end

   // lk masks buttons still held from an alarm until released
   assign en      = db & ~lk;
   assign rise    = db & ~db_q;
   assign hp      = en[0] & ~en[1];
   assign hm      = en[1] & ~en[0];
   assign fresh_p = hp & ~hp_q;
   assign fresh_m = hm & ~hm_q;
   assign srise   = rise[2] & ~lk[2];

   assign rtgt  = rep ? RW'(REPEAT_RATE) : RW'(REPEAT_DELAY);
   assign rtick = (hp | hm) && (rcnt != '0) && (rcnt == rtgt);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         tmr_plus  <= 1'b0;
         tmr_minus <= 1'b0;
         tmr_start <= 1'b0;
         tmr_reset <= 1'b0;
         buzzer    <= 1'b0;
         db_q      <= '0;
         lk        <= '0;
         hp_q      <= 1'b0;
         hm_q      <= 1'b0;
         rcnt      <= '0;
         rep       <= 1'b0;
         pcnt      <= '0;
         bleft     <= '0;
      end else begin
         tmr_plus  <= 1'b0;
         tmr_minus <= 1'b0;
         tmr_start <= 1'b0;
         tmr_reset <= 1'b0;
         buzzer    <= 1'b0;
         db_q      <= db;
         hp_q      <= hp;
         hm_q      <= hm;
         lk        <= (state == S_ALARM) ? db : (lk & db);

         if (state != S_IDLE || !(hp | hm)) begin
            rcnt <= '0;
            rep  <= 1'b0;
         end else if (fresh_p | fresh_m) begin
            rcnt <= RW'(1);
            rep  <= 1'b0;
         end else if (rtick) begin
            rcnt <= RW'(1);
            rep  <= 1'b1;
         end else if (rcnt != '0) begin
            rcnt <= rcnt + 1'b1;
         end

         unique case (1'b1)
            (state == S_IDLE): begin
               if (srise) begin
                  tmr_start <= 1'b1;
                  state     <= S_RUN;
               end else if (fresh_p | (rtick & hp)) begin
                  tmr_plus <= 1'b1;
               end else if (fresh_m | (rtick & hm)) begin
                  tmr_minus <= 1'b1;
               end
            end
            (state == S_RUN): begin
               if (timer_finish) begin
                  state  <= S_ALARM;
                  buzzer <= 1'b1;
                  pcnt   <= '0;
                  bleft  <= 4'(BEEP_COUNT);
               end else if (srise) begin
                  tmr_reset <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            (state == S_ALARM): begin
               if (|rise) begin
                  tmr_reset <= 1'b1;
                  state     <= S_IDLE;
               end else if (pcnt != BW'(BEEP_LEN - 1)) begin
                  pcnt   <= pcnt + 1'b1;
                  buzzer <= buzzer;
               end else begin
                  pcnt <= '0;
                  if (!buzzer && bleft == 4'd1) begin
                     tmr_reset <= 1'b1;
                     state     <= S_IDLE;
                  end else begin
                     buzzer <= ~buzzer;
                     if (!buzzer) bleft <= bleft - 1'b1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_timer_panel.sv
// Directed bench for timer_panel at default parameters.
module tb_timer_panel;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       btn_plus;
   logic       btn_minus;
   logic       btn_start;
   logic       timer_finish;
   logic       tmr_plus;
   logic       tmr_minus;
   logic       tmr_start;
   logic       tmr_reset;
   logic       buzzer;
   logic [1:0] state;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int multi    = 0;
   int bzc      = 0;
   int pq[$];
   int mq[$];
   int sq[$];
   int rq[$];
   int t;
   int p;

   timer_panel dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .btn_plus     (btn_plus),
      .btn_minus    (btn_minus),
      .btn_start    (btn_start),
      .timer_finish (timer_finish),
      .tmr_plus     (tmr_plus),
      .tmr_minus    (tmr_minus),
      .tmr_start    (tmr_start),
      .tmr_reset    (tmr_reset),
      .buzzer       (buzzer),
      .state        (state)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (tmr_plus)  pq.push_back(cyc);
      if (tmr_minus) mq.push_back(cyc);
      if (tmr_start) sq.push_back(cyc);
      if (tmr_reset) rq.push_back(cyc);
      if ($countones({tmr_plus, tmr_minus, tmr_start, tmr_reset}) > 1)
         multi++;
      if (buzzer) bzc++;
   end

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic drv();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cyc(input int n);
      do @(negedge clk); while (cyc < n);
   endtask

   task automatic clr();
      pq.delete();
      mq.delete();
      sq.delete();
      rq.delete();
   endtask

   task automatic enter_run();
      drv();
      btn_start = 1'b1;
      repeat (8) drv();
      btn_start = 1'b0;
      repeat (8) drv();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=%0d exp=0", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      reset_n      = 1'b0;
      btn_plus     = 1'b0;
      btn_minus    = 1'b0;
      btn_start    = 1'b0;
      timer_finish = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_state", state, 0);
      chk("rst_outs", {tmr_plus, tmr_minus, tmr_start, tmr_reset}, 0);
      chk("rst_buzz", buzzer, 0);
      drv();
      reset_n = 1'b1;
      repeat (3) drv();

      // single press with auto-repeat
      drv();
      t = cyc;
      btn_plus = 1'b1;
      clr();
      repeat (20) drv();
      btn_plus = 1'b0;
      repeat (12) drv();
      chk("plus_n", pq.size(), 4);
      chk("plus_0", pq[0], t + 7);
      chk("plus_1", pq[1], t + 15);
      chk("plus_2", pq[2], t + 19);
      chk("plus_3", pq[3], t + 23);
      chk("plus_mn", mq.size(), 0);

      // both held, then minus released
      drv();
      t = cyc;
      btn_plus  = 1'b1;
      btn_minus = 1'b1;
      clr();
      repeat (10) drv();
      btn_minus = 1'b0;
      repeat (8) drv();
      btn_plus = 1'b0;
      repeat (12) drv();
      chk("both_pn", pq.size(), 1);
      chk("both_p0", pq[0], t + 17);
      chk("both_mn", mq.size(), 0);

      // bouncing minus
      drv();
      t = cyc;
      clr();
      for (int k = 0; k < 10; k++) begin
         btn_minus = k[1];
         drv();
      end
      btn_minus = 1'b1;
      repeat (4) drv();
      btn_minus = 1'b0;
      repeat (10) drv();
      chk("bnc_mn", mq.size(), 1);
      chk("bnc_m0", mq[0], t + 17);

      // start then abort
      drv();
      t = cyc;
      btn_start = 1'b1;
      clr();
      wait_cyc(t + 6);
      chk("st_pre", state, 0);
      wait_cyc(t + 7);
      chk("st_run", state, 1);
      chk("st_pulse", tmr_start, 1);
      drv();
      btn_start = 1'b0;
      repeat (8) drv();
      drv();
      t = cyc;
      btn_start = 1'b1;
      wait_cyc(t + 7);
      chk("ab_state", state, 0);
      chk("ab_pulse", tmr_reset, 1);
      drv();
      btn_start = 1'b0;
      repeat (10) drv();
      chk("ab_sn", sq.size(), 1);
      chk("ab_rn", rq.size(), 1);

      // full alarm
      enter_run();
      chk("al_run", state, 1);
      drv();
      t = cyc;
      timer_finish = 1'b1;
      clr();
      bzc = 0;
      drv();
      timer_finish = 1'b0;
      wait_cyc(t + 1);
      chk("al_state", state, 2);
      chk("al_bz1", buzzer, 1);
      wait_cyc(t + 6);
      chk("al_bz6", buzzer, 1);
      wait_cyc(t + 7);
      chk("al_bz7", buzzer, 0);
      wait_cyc(t + 12);
      chk("al_bz12", buzzer, 0);
      wait_cyc(t + 13);
      chk("al_bz13", buzzer, 1);
      wait_cyc(t + 31);
      chk("al_bz31", buzzer, 0);
      wait_cyc(t + 36);
      chk("al_st36", state, 2);
      chk("al_rst36", tmr_reset, 0);
      wait_cyc(t + 37);
      chk("al_st37", state, 0);
      chk("al_rst37", tmr_reset, 1);
      repeat (3) drv();
      chk("al_bzc", bzc, 18);
      chk("al_rn", rq.size(), 1);

      // alarm cut short by plus, held afterwards
      enter_run();
      drv();
      t = cyc;
      timer_finish = 1'b1;
      clr();
      drv();
      timer_finish = 1'b0;
      while (cyc < t + 10) drv();
      btn_plus = 1'b1;
      wait_cyc(t + 16);
      chk("ap_bz16", buzzer, 1);
      chk("ap_st16", state, 2);
      wait_cyc(t + 17);
      chk("ap_bz17", buzzer, 0);
      chk("ap_st17", state, 0);
      chk("ap_rst", tmr_reset, 1);
      while (cyc < t + 40) drv();
      btn_plus = 1'b0;
      repeat (10) drv();
      chk("ap_pn", pq.size(), 0);
      chk("ap_rn", rq.size(), 1);

      // start and finish together
      enter_run();
      drv();
      t = cyc;
      btn_start = 1'b1;
      clr();
      while (cyc < t + 6) drv();
      timer_finish = 1'b1;
      drv();
      timer_finish = 1'b0;
      wait_cyc(t + 7);
      chk("sf_state", state, 2);
      chk("sf_rst", tmr_reset, 0);
      drv();
      btn_start = 1'b0;
      wait_cyc(t + 44);
      chk("sf_end", state, 0);
      chk("sf_r0", rq[0], t + 43);

      // reset during auto-repeat
      repeat (4) drv();
      drv();
      p = cyc;
      btn_plus = 1'b1;
      clr();
      while (cyc < p + 16) drv();
      chk("rr_pre", pq.size(), 2);
      reset_n = 1'b0;
      pq.delete();
      drv();
      reset_n = 1'b1;
      wait_cyc(p + 17);
      chk("rr_outs", {tmr_plus, tmr_minus, tmr_start, tmr_reset,
                      buzzer}, 0);
      chk("rr_state", state, 0);
      while (cyc < p + 30) drv();
      btn_plus = 1'b0;
      repeat (10) drv();
      chk("rr_p0", pq[0], p + 24);

      chk("onehot", multi, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
